ma_request_arbiter: RTL and testbench
=====================================

# ma_request_arbiter

Shares the single Memory Access (MA) request/result port among up to four pipeline stages (e.g. the node-lookup/insert stage on channel 1). Round-robin arbitration over per-stage request streams, a one-entry registered output slot to MA, per-channel outstanding-result credit counters, and routing of MA results back to the originating stage by channel ID.

## Interface
Parameters:
- NUM_PORTS, 4: requesters; channel ID = port index (2 bits).
- REQ_WIDTH, 128: MA request payload width.
- RES_WIDTH, 96: MA result payload width.
- MAX_OUTSTANDING, 4: max result-expecting requests in flight per channel (1..15).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_data  in  NUM_PORTS*REQ_WIDTH  request payloads; port i at [i*REQ_WIDTH +: REQ_WIDTH].
- req_expects_result  in  NUM_PORTS  1 = request will produce an MA result (fetch, insert); 0 = none (write-next).
- req_valid  in  NUM_PORTS  request present.
- req_ready  out  NUM_PORTS  request accepted this cycle when high with req_valid.
- aso_request_data  out  REQ_WIDTH  request to MA.
- aso_request_channel  out  2  originating port.
- aso_request_valid  out  1  slot holds a request.
- aso_request_ready  in  1  MA accepts.
- asi_result_data  in  RES_WIDTH  MA result.
- asi_result_channel  in  2  destination port.
- asi_result_valid  in  1  result present.
- asi_result_ready  out  1  tied 1.
- res_data  out  RES_WIDTH  registered result, broadcast to all ports.
- res_valid  out  NUM_PORTS  one-hot registered result strobe.
- err_unexpected  out  1  sticky: result arrived for a channel with zero outstanding, or channel ≥ NUM_PORTS.

## Operation
- Slot: one register (data, channel, valid). Slot loadable ("open") when slot empty or aso_request_ready=1.
- Eligible(i) = req_valid[i] & (!req_expects_result[i] | cnt[i] < MAX_OUTSTANDING).
- Grant: first eligible port scanning from rr_ptr upward, wrapping mod NUM_PORTS. At most one req_ready bit high; req_ready[i] = grant[i] & open. req_ready is combinational from req_valid, counters, rr_ptr, slot state and aso_request_ready.
- On accept of port i: slot <= {req_data[i], i}, valid <= 1; rr_ptr <= (i+1) mod NUM_PORTS; cnt[i] += 1 if req_expects_result[i].
- Slot drains when aso_request_valid & aso_request_ready with no new accept: valid <= 0. Slot contents stable while valid & !ready.
- rr_ptr unchanged on cycles with no accept.
- Result path: on asi_result_valid with channel c < NUM_PORTS and cnt[c] > 0: res_data <= asi_result_data, res_valid <= onehot(c), cnt[c] -= 1. Otherwise res_valid <= 0. Unmatched results are dropped, set err_unexpected, and leave counters unchanged.
- Same-cycle increment and decrement on the same channel: cnt unchanged. A result frees a credit usable from the next cycle, not the same cycle.
- err_unexpected clears only on reset.

## Timing
- Reset (reset=0, asynchronous): aso_request_valid=0, aso_request_data=0, aso_request_channel=0, res_valid=0, res_data=0, err_unexpected=0, all cnt=0, rr_ptr=0. req_ready=0 while in reset. asi_result_ready=1 always.
- Request accepted on edge N is presented on aso_request_* from N+1. Full throughput of one request per cycle while aso_request_ready=1.
- Result sampled on edge N appears on res_data/res_valid for exactly one cycle after N.
- Reset mid-operation discards the slot and all credits. Requesters must reissue.

## Test plan
- Single port: port 1 issues fetch (expects=1) with aso_request_ready=1 -> aso_request_valid next cycle, channel=1, data matches. cnt[1]=1. MA result channel 1 -> res_valid=4'b0010 one cycle later, cnt[1]=0.
- Fairness: all four ports valid continuously, ready=1 -> grant order 0,1,2,3,0,1,…, one per cycle, no gaps.
- Backpressure: aso_request_ready=0 for 5 cycles with slot full -> slot data/channel stable, req_ready=0. Release -> drains, next grant loaded the same cycle.
- Credits: MAX_OUTSTANDING=4, port 2 issues 5 expecting requests, no results -> 5th stalls (req_ready[2]=0) while port 3 non-expecting requests proceed. One result for channel 2 -> 5th accepted the following cycle.
- Non-expecting write-next from port 0 -> forwarded, cnt[0] stays 0. Result for channel 0 -> dropped, res_valid=0, err_unexpected=1 and sticky.
- Assert reset with slot full and cnt[1]=3 -> aso_request_valid=0 immediately, counters 0, rr_ptr 0. After release, port 3 alone is granted correctly.

Source files
------------

// File: rtl/ma_request_arbiter.sv
// ma_request_arbiter: shares the single Memory Access request/result port
// among up to four pipeline stages. Round-robin arbitration feeds a one-entry
// output slot, per-channel credit counters bound outstanding result-expecting
// requests, and MA results are routed back to their stage by channel ID.
module ma_request_arbiter #(
    parameter int NUM_PORTS       = 4,
    parameter int REQ_WIDTH       = 128,
    parameter int RES_WIDTH       = 96,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PORTS*REQ_WIDTH-1:0] req_data,
    input  logic [NUM_PORTS-1:0]           req_expects_result,
    input  logic [NUM_PORTS-1:0]           req_valid,
    output logic [NUM_PORTS-1:0]           req_ready,
    output logic [REQ_WIDTH-1:0]           aso_request_data,
    output logic [1:0]                     aso_request_channel,
    output logic                           aso_request_valid,
    input  logic                           aso_request_ready,
    input  logic [RES_WIDTH-1:0]           asi_result_data,
    input  logic [1:0]                     asi_result_channel,
    input  logic                           asi_result_valid,
    output logic                           asi_result_ready,
    output logic [RES_WIDTH-1:0]           res_data,
    output logic [NUM_PORTS-1:0]           res_valid,
    output logic                           err_unexpected
);

    localparam int CHW = 2;
    localparam int CW  = 4;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    logic [REQ_WIDTH-1:0] slot_data_q, slot_data_d;
    logic [CHW-1:0]       slot_chan_q, slot_chan_d;
    logic                 slot_valid_q, slot_valid_d;
    logic [CHW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]        cnt_q [NUM_PORTS];
    logic [CW-1:0]        cnt_d [NUM_PORTS];
    logic [RES_WIDTH-1:0] res_data_q, res_data_d;
    logic [NUM_PORTS-1:0] res_valid_q, res_valid_d;
    logic                 err_q, err_d;

    logic                 slot_open;
    logic                 grant_found;
    logic                 accept;
    logic                 res_match;
    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] grant;
    logic [NUM_PORTS-1:0] res_hit;
    logic [REQ_WIDTH-1:0] grant_data;

    // Pick the first eligible port scanning upward from rr_ptr, with wrap.
    always_comb begin
        eligible    = '0;
        grant       = '0;
        grant_found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            eligible[i] = req_valid[i] & (~req_expects_result[i] | (cnt_q[i] < MAX_CNT));
        end
        for (int k = 0; k < NUM_PORTS; k++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!grant_found && eligible[i] && (i == ((int'(rr_ptr_q) + k) % NUM_PORTS))) begin
                    grant[i]    = 1'b1;
                    grant_found = 1'b1;
                end
            end
        end
    end

    // Handshake with requesters; nothing is accepted while reset is asserted.
    always_comb begin
        slot_open  = ~slot_valid_q | aso_request_ready;
        accept     = grant_found & slot_open & reset;
        req_ready  = grant & {NUM_PORTS{slot_open & reset}};
        grant_data = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                grant_data = req_data[i*REQ_WIDTH +: REQ_WIDTH];
            end
        end
    end

    // Load the slot on accept, drain it when MA takes it, otherwise hold.
    always_comb begin
        slot_data_d  = slot_data_q;
        slot_chan_d  = slot_chan_q;
        slot_valid_d = slot_valid_q;
        rr_ptr_d     = rr_ptr_q;
        if (accept) begin
            slot_data_d  = grant_data;
            slot_valid_d = 1'b1;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (grant[i]) begin
                    slot_chan_d = CHW'(i);
                    rr_ptr_d    = CHW'((i + 1) % NUM_PORTS);
                end
            end
        end else if (slot_valid_q && aso_request_ready) begin
            slot_valid_d = 1'b0;
        end
    end

    // Route matched results back, consume credits, flag unmatched results.
    always_comb begin
        res_hit = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            res_hit[i] = asi_result_valid && (asi_result_channel == CHW'(i)) && (cnt_q[i] != '0);
        end
        res_match   = |res_hit;
        res_valid_d = res_hit;
        res_data_d  = res_match ? asi_result_data : res_data_q;
        err_d       = err_q | (asi_result_valid & ~res_match);
        for (int i = 0; i < NUM_PORTS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (accept && grant[i] && req_expects_result[i]) begin
                cnt_d[i] = cnt_d[i] + CW'(1);
            end
            if (res_hit[i]) begin
                cnt_d[i] = cnt_d[i] - CW'(1);
            end
        end
    end

    // State registers; reset discards the slot and all credits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_data_q  <= '0;
            slot_chan_q  <= '0;
            slot_valid_q <= 1'b0;
            rr_ptr_q     <= '0;
            res_data_q   <= '0;
            res_valid_q  <= '0;
            err_q        <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            slot_data_q  <= slot_data_d;
            slot_chan_q  <= slot_chan_d;
            slot_valid_q <= slot_valid_d;
            rr_ptr_q     <= rr_ptr_d;
            res_data_q   <= res_data_d;
            res_valid_q  <= res_valid_d;
            err_q        <= err_d;
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign aso_request_data    = slot_data_q;
    assign aso_request_channel = slot_chan_q;
    assign aso_request_valid   = slot_valid_q;
    assign asi_result_ready    = 1'b1;
    assign res_data            = res_data_q;
    assign res_valid           = res_valid_q;
    assign err_unexpected      = err_q;

endmodule

// File: tb/tb_ma_request_arbiter.sv
// Testbench for ma_request_arbiter: a hand-computed vector table, directed
// credit and mid-operation reset sequences, then randomized traffic checked
// against a behavioural model of the arbiter.
module tb_ma_request_arbiter;

    localparam int NP = 4;
    localparam int RW = 128;
    localparam int SW = 96;
    localparam int MAXO = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [NP*RW-1:0] req_data;
    logic [NP-1:0]   req_expects_result;
    logic [NP-1:0]   req_valid;
    logic [NP-1:0]   req_ready;
    logic [RW-1:0]   aso_request_data;
    logic [1:0]      aso_request_channel;
    logic            aso_request_valid;
    logic            aso_request_ready;
    logic [SW-1:0]   asi_result_data;
    logic [1:0]      asi_result_channel;
    logic            asi_result_valid;
    logic            asi_result_ready;
    logic [SW-1:0]   res_data;
    logic [NP-1:0]   res_valid;
    logic            err_unexpected;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Behavioural model state
    int          m_cnt [NP];
    int          m_rr;
    bit          m_sv;
    logic [RW-1:0] m_sd;
    int          m_sc;
    logic [SW-1:0] m_rd;
    logic [NP-1:0] m_rv;
    bit          m_err;

    typedef struct {
        logic [3:0] rv;
        logic [3:0] ex;
        logic       ar;
        logic       resv;
        logic [1:0] resc;
        logic [3:0] e_ready;
        logic       e_aso_v;
        logic [1:0] e_aso_ch;
        logic [3:0] e_res_v;
        logic       e_err;
    } vec_t;

    vec_t vecs [13];

    localparam logic [SW-1:0] TBL_RES = 96'h0123_4567_89AB_CDEF_0011_2233;

    ma_request_arbiter #(
        .NUM_PORTS(NP), .REQ_WIDTH(RW), .RES_WIDTH(SW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_data(req_data),
        .req_expects_result(req_expects_result),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .aso_request_data(aso_request_data),
        .aso_request_channel(aso_request_channel),
        .aso_request_valid(aso_request_valid),
        .aso_request_ready(aso_request_ready),
        .asi_result_data(asi_result_data),
        .asi_result_channel(asi_result_channel),
        .asi_result_valid(asi_result_valid),
        .asi_result_ready(asi_result_ready),
        .res_data(res_data),
        .res_valid(res_valid),
        .err_unexpected(err_unexpected)
    );

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] pattern(input int ch);
        return {4{32'hD00D_0000 + 32'(ch)}};
    endfunction

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic modelReset();
        for (int i = 0; i < NP; i++) m_cnt[i] = 0;
        m_rr = 0; m_sv = 0; m_sd = '0; m_sc = 0; m_rd = '0; m_rv = '0; m_err = 0;
    endtask

    // Round-robin choice from the model's view of credits and pointer.
    function automatic logic [NP-1:0] modelReady();
        int idx;
        if (!reset) return '0;
        if (m_sv && !aso_request_ready) return '0;
        for (int k = 0; k < NP; k++) begin
            idx = (m_rr + k) % NP;
            if (req_valid[idx] && (!req_expects_result[idx] || m_cnt[idx] < MAXO))
                return NP'(1 << idx);
        end
        return '0;
    endfunction

    // Advance the model by one clock edge using the inputs held across it.
    task automatic modelStep();
        logic [NP-1:0] g;
        int c;
        bit hit;
        if (!reset) begin
            modelReset();
            return;
        end
        g = modelReady();
        c = int'(asi_result_channel);
        hit = asi_result_valid && (c < NP) && (m_cnt[c] > 0);
        for (int i = 0; i < NP; i++) begin
            if (g[i]) begin
                m_sv = 1; m_sd = req_data[i*RW +: RW]; m_sc = i; m_rr = (i + 1) % NP;
                if (req_expects_result[i]) m_cnt[i]++;
            end
        end
        if (g == '0 && m_sv && aso_request_ready) m_sv = 0;
        if (hit) begin
            m_rd = asi_result_data; m_rv = NP'(1 << c); m_cnt[c]--;
        end else begin
            m_rv = '0;
        end
        if (asi_result_valid && !hit) m_err = 1;
    endtask

    task automatic applyStimulus(input logic [3:0] rv, input logic [3:0] ex, input logic ar,
                                 input logic resv, input logic [1:0] resc, input bit rnd_data);
        req_valid = rv; req_expects_result = ex; aso_request_ready = ar;
        asi_result_valid = resv; asi_result_channel = resc;
        if (rnd_data) begin
            for (int w = 0; w < NP*RW/32; w++) req_data[w*32 +: 32] = $urandom;
            for (int w = 0; w < SW/32; w++) asi_result_data[w*32 +: 32] = $urandom;
        end else begin
            for (int i = 0; i < NP; i++) req_data[i*RW +: RW] = pattern(i);
            asi_result_data = TBL_RES;
        end
    endtask

    task automatic checkOutput();
        check("req_ready", RW'(req_ready), RW'(modelReady()));
        check("aso_valid", RW'(aso_request_valid), RW'(m_sv));
        if (m_sv) begin
            check("aso_data", aso_request_data, m_sd);
            check("aso_channel", RW'(aso_request_channel), RW'(m_sc));
        end
        check("res_valid", RW'(res_valid), RW'(m_rv));
        if (m_rv != '0) check("res_data", RW'(res_data), RW'(m_rd));
        check("err_unexpected", RW'(err_unexpected), RW'(m_err));
        check("asi_result_ready", RW'(asi_result_ready), RW'(1'b1));
    endtask

    // Settle, compare, then cross one clock edge with the model in step.
    task automatic stepCycle();
        #1;
        checkOutput();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic doReset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        modelReset();
        applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0);
        #1;
        check("rst_aso_data", aso_request_data, '0);
        check("rst_aso_channel", RW'(aso_request_channel), '0);
        check("rst_res_data", RW'(res_data), '0);
        check("rst_req_ready", RW'(req_ready), '0);
        checkOutput();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0);
    endtask

    initial begin
        logic [3:0] cr_rv [8];
        logic       cr_res [8];
        logic [3:0] cr_exp [8];

        // rv, ex, ar, resv, resc, e_ready, e_aso_v, e_aso_ch, e_res_v, e_err
        vecs[0]  = '{4'b0010, 4'b0010, 1, 0, 2'd0, 4'b0010, 0, 2'd0, 4'b0000, 0};
        vecs[1]  = '{4'b0000, 4'b0000, 1, 1, 2'd1, 4'b0000, 1, 2'd1, 4'b0000, 0};
        vecs[2]  = '{4'b0000, 4'b0000, 1, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0010, 0};
        vecs[3]  = '{4'b1111, 4'b0000, 1, 0, 2'd0, 4'b0100, 0, 2'd0, 4'b0000, 0};
        vecs[4]  = '{4'b1111, 4'b0000, 1, 0, 2'd0, 4'b1000, 1, 2'd2, 4'b0000, 0};
        vecs[5]  = '{4'b1111, 4'b0000, 1, 0, 2'd0, 4'b0001, 1, 2'd3, 4'b0000, 0};
        vecs[6]  = '{4'b1111, 4'b0000, 1, 0, 2'd0, 4'b0010, 1, 2'd0, 4'b0000, 0};
        vecs[7]  = '{4'b1111, 4'b0000, 0, 0, 2'd0, 4'b0000, 1, 2'd1, 4'b0000, 0};
        vecs[8]  = '{4'b1111, 4'b0000, 0, 0, 2'd0, 4'b0000, 1, 2'd1, 4'b0000, 0};
        vecs[9]  = '{4'b1111, 4'b0000, 1, 0, 2'd0, 4'b0100, 1, 2'd1, 4'b0000, 0};
        vecs[10] = '{4'b0000, 4'b0000, 1, 1, 2'd0, 4'b0000, 1, 2'd2, 4'b0000, 0};
        vecs[11] = '{4'b0000, 4'b0000, 1, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 1};
        vecs[12] = '{4'b0000, 4'b0000, 1, 0, 2'd0, 4'b0000, 0, 2'd0, 4'b0000, 1};

        // Credit sequence for port 2 with port 3 issuing write-next requests.
        cr_rv  = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1100, 4'b1100, 4'b0100};
        cr_res = '{0, 0, 0, 0, 0, 0, 1, 0};
        cr_exp = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0100};

        reset = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0);
        doReset();

        for (int n = 0; n < 13; n++) begin
            applyStimulus(vecs[n].rv, vecs[n].ex, vecs[n].ar, vecs[n].resv, vecs[n].resc, 1'b0);
            #1;
            check($sformatf("tbl%0d_ready", n), RW'(req_ready), RW'(vecs[n].e_ready));
            check($sformatf("tbl%0d_aso_v", n), RW'(aso_request_valid), RW'(vecs[n].e_aso_v));
            if (vecs[n].e_aso_v) begin
                check($sformatf("tbl%0d_aso_ch", n), RW'(aso_request_channel), RW'(vecs[n].e_aso_ch));
                check($sformatf("tbl%0d_aso_data", n), aso_request_data, pattern(int'(vecs[n].e_aso_ch)));
            end
            check($sformatf("tbl%0d_res_v", n), RW'(res_valid), RW'(vecs[n].e_res_v));
            if (vecs[n].e_res_v != '0) check($sformatf("tbl%0d_res_data", n), RW'(res_data), RW'(TBL_RES));
            check($sformatf("tbl%0d_err", n), RW'(err_unexpected), RW'(vecs[n].e_err));
            @(posedge clk);
            modelStep();
            #1;
        end

        doReset();
        for (int n = 0; n < 8; n++) begin
            applyStimulus(cr_rv[n], 4'b0100, 1'b1, cr_res[n], 2'd2, 1'b1);
            #1;
            check($sformatf("credit%0d_ready", n), RW'(req_ready), RW'(cr_exp[n]));
            checkOutput();
            @(posedge clk);
            modelStep();
            #1;
        end
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b1);
        stepCycle();

        // Fill port 1 credits to three and hold the slot full, then reset.
        doReset();
        for (int n = 0; n < 3; n++) begin
            applyStimulus(4'b0010, 4'b0010, 1'b1, 1'b0, 2'd0, 1'b1);
            stepCycle();
        end
        applyStimulus(4'b0010, 4'b0010, 1'b0, 1'b0, 2'd0, 1'b1);
        stepCycle();
        #2;
        reset = 1'b0;
        modelReset();
        #1;
        check("midrst_aso_valid", RW'(aso_request_valid), '0);
        check("midrst_req_ready", RW'(req_ready), '0);
        check("midrst_res_valid", RW'(res_valid), '0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        applyStimulus(4'b1000, 4'b1000, 1'b1, 1'b0, 2'd0, 1'b1);
        #1;
        check("post_rst_port3", RW'(req_ready), RW'(4'b1000));
        @(posedge clk);
        modelStep();
        #1;
        applyStimulus(4'b1111, 4'b0010, 1'b1, 1'b0, 2'd0, 1'b1);
        #1;
        check("post_rst_rr_wrap", RW'(req_ready), RW'(4'b0001));
        checkOutput();
        @(posedge clk);
        modelStep();
        #1;
        for (int n = 0; n < 4; n++) begin
            applyStimulus(4'b0010, 4'b0010, 1'b1, 1'b0, 2'd0, 1'b1);
            #1;
            check($sformatf("post_rst_credit%0d", n), RW'(req_ready), RW'(4'b0010));
            @(posedge clk);
            modelStep();
            #1;
        end

        // Randomized traffic against the behavioural model.
        for (int n = 0; n < 2000; n++) begin
            applyStimulus(4'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 2) == 0), 2'($urandom), 1'b1);
            stepCycle();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
